ring_shift_n: RTL and testbench
===============================

Name: ring_shift_n

Overview:
- Parametrised successor to the team's fixed 5-stage D-flip-flop ring counter.
- WIDTH-bit register with four modes: ring rotate, Johnson (twisted ring), serial shift, and parallel load.
- Adds direction control, clock enable, a revolution step counter and a wrap pulse.
- Used as a one-hot sequencer / phase generator feeding downstream control logic; q is fully registered.

Parameters:
- WIDTH, 5, number of stages; legal range WIDTH >= 2.
- RESET_VAL, 0 (WIDTH bits), value loaded into q on clear.

Ports:
- clk  input  1  clock; all state updates on its posedge.
- clear  input  1  reset; synchronous, active-high.
- en  input  1  step enable; 0 = hold all state.
- mode  input  2  00 ring, 01 Johnson, 10 serial shift, 11 parallel load.
- dir  input  1  0 = shift toward MSB (q[0]->q[1]->...); 1 = toward LSB.
- sin  input  1  serial input to the entry stage.
- load_val  input  WIDTH  parallel load data.
- q  output  WIDTH  stage outputs.
- step_cnt  output  CW  shifts since last clear/load, modulo WIDTH; CW = $clog2(WIDTH).
- wrap  output  1  one-cycle pulse marking a completed revolution.

Behaviour:
- Every output is a register; there is no combinational path from inputs to outputs.
- Reset (clear=1 at posedge): q<=RESET_VAL, step_cnt<=0, wrap<=0.
  - clear has priority over en, mode and load.
  - Applying clear mid-operation discards the shift in that cycle.
- Hold (en=0, clear=0): q and step_cnt keep their values; wrap<=0.
- Entry and exit stages:
  - dir=0: entry q[0], exit q[WIDTH-1]; q[i]<=q[i-1] for i>=1.
  - dir=1: entry q[WIDTH-1], exit q[0]; q[i]<=q[i+1] for i<WIDTH-1.
- Entry-stage value by mode (en=1):
  - ring (00): entry <= exit | sin. sin injects tokens; existing tokens recirculate.
  - Johnson (01): entry <= ~exit; sin ignored; period is 2*WIDTH.
  - shift (10): entry <= sin; exit bit discarded.
  - load (11): q<=load_val; step_cnt<=0; wrap<=0; no shift takes place.
- step_cnt, in the shifting modes (00/01/10, en=1):
  - step_cnt<=step_cnt+1; at WIDTH-1 it wraps to 0.
  - Arithmetic is modulo WIDTH, not 2^CW.
- wrap:
  - wrap<=1 in the cycle the counter rolls from WIDTH-1 to 0, else 0.
  - It is therefore high for exactly one cycle per WIDTH shifts.
  - Hold, load and clear cycles drive wrap low.
- Latency: one clock from the input sample to the visible q, step_cnt and wrap.
- Changes to mode or dir take effect at the next enabled edge. No pipeline state is carried across a change; step_cnt continues counting across mode/dir changes.
- All-zero ring with sin=0 stays all-zero; no self-correction of multi-hot or empty patterns.
- Johnson started from a non-Johnson pattern simply follows the entry rule; no illegal-state recovery is required.

Test Plan:
- Reset: WIDTH=5, RESET_VAL=0; clear=1 for 2 cycles with en=1, mode=00, sin=1 -> q=00000, step_cnt=0, wrap=0. Repeat with RESET_VAL=10101 -> q=10101.
- Ring, dir=0: after clear, en=1, sin=1 for 1 cycle, then sin=0.
  - q (q[4:0]) = 00001, 00010, 00100, 01000, 10000, 00001.
  - step_cnt = 1, 2, 3, 4, 0, 1.
  - wrap is 1 only alongside q=10000.
- Johnson, dir=0, from 00000 -> 00001, 00011, 00111, 01111, 11111, 11110, 11100, 11000, 10000, 00000; repeats with period 10.
- Load, dir=1, ring: load 00001, then ring -> 10000, 01000, 00100. Then en=0 for 3 cycles -> q holds 00100, wrap=0, step_cnt holds 3.
- Shift, dir=0: after clear, sin = 1, 0, 1, 1, 0 over 5 cycles -> q=10110, step_cnt=0, wrap=1 on the 5th cycle.
- Priority: during ring rotation assert clear together with mode=11 and load_val=11111 -> q=RESET_VAL, step_cnt=0. Next cycle mode=11 with clear=0 -> q=11111, step_cnt=0.

Source files
------------

// File: rtl/ring_shift_n.sv
// Parametrised ring / Johnson / serial-shift register with parallel load,
// direction control, a modulo-WIDTH step counter and a one-cycle wrap pulse.
module ring_shift_n #(
  parameter int               WIDTH     = 5,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       clear,
  input  logic                       en,
  input  logic [1:0]                 mode,
  input  logic                       dir,
  input  logic                       sin,
  input  logic [WIDTH-1:0]           load_val,
  output logic [WIDTH-1:0]           q,
  output logic [$clog2(WIDTH)-1:0]   step_cnt,
  output logic                       wrap
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] MODE_RING    = 2'b00;
  localparam logic [1:0] MODE_JOHNSON = 2'b01;
  localparam logic [1:0] MODE_SHIFT   = 2'b10;
  localparam logic [1:0] MODE_LOAD    = 2'b11;

  logic [WIDTH-1:0] q_reg, q_next;
  logic [WIDTH-1:0] shl_next, shr_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             wrap_reg, wrap_next;
  logic             exit_bit, entry_bit, cnt_last;

  assign exit_bit = dir ? q_reg[0] : q_reg[WIDTH-1];

  always_comb begin
    entry_bit = sin;
    case (mode)
      MODE_RING:    entry_bit = exit_bit | sin;
      MODE_JOHNSON: entry_bit = ~exit_bit;
      MODE_SHIFT:   entry_bit = sin;
      default:      entry_bit = sin;
    endcase
  end

  // Both shift directions are built in parallel; dir just picks one.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_stage
      if (gi == 0) begin : g_lsb
        assign shl_next[gi] = entry_bit;
      end else begin : g_up
        assign shl_next[gi] = q_reg[gi-1];
      end
      if (gi == WIDTH-1) begin : g_msb
        assign shr_next[gi] = entry_bit;
      end else begin : g_down
        assign shr_next[gi] = q_reg[gi+1];
      end
    end
  endgenerate

  // Counter rolls over at WIDTH-1, not at 2^CW-1.
  assign cnt_last = (cnt_reg == CW'(WIDTH-1));

  always_comb begin
    q_next    = q_reg;
    cnt_next  = cnt_reg;
    wrap_next = 1'b0;
    if (en) begin
      if (mode == MODE_LOAD) begin
        q_next   = load_val;
        cnt_next = '0;
      end else begin
        q_next    = dir ? shr_next : shl_next;
        cnt_next  = cnt_last ? '0 : cnt_reg + CW'(1);
        wrap_next = cnt_last;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      q_reg    <= RESET_VAL;
      cnt_reg  <= '0;
      wrap_reg <= 1'b0;
    end else begin
      q_reg    <= q_next;
      cnt_reg  <= cnt_next;
      wrap_reg <= wrap_next;
    end
  end

  assign q        = q_reg;
  assign step_cnt = cnt_reg;
  assign wrap     = wrap_reg;

endmodule

// File: tb/tb_ring_shift_n.sv
// Bench for ring_shift_n: two WIDTH=5 instances (reset values 0 and 10101)
// share stimulus and are compared against an arithmetic reference model.
module tb_ring_shift_n;

  localparam int W = 5;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         clear, en, dir, sin;
  logic [1:0]   mode;
  logic [W-1:0] load_val;
  logic [W-1:0] q_a, q_b;
  logic [2:0]   cnt_a, cnt_b;
  logic         wrap_a, wrap_b;

  int n_checks = 0;
  int n_errors = 0;

  // reference state, index 0 = dut_a, 1 = dut_b
  int m_q[2];
  int m_cnt[2];
  int m_wrap[2];
  int m_rv[2] = '{0, 21};

  always #5 clk = ~clk;

  ring_shift_n #(.WIDTH(W), .RESET_VAL(5'b00000)) dut_a (
    .clk(clk), .clear(clear), .en(en), .mode(mode), .dir(dir), .sin(sin),
    .load_val(load_val), .q(q_a), .step_cnt(cnt_a), .wrap(wrap_a)
  );

  ring_shift_n #(.WIDTH(W), .RESET_VAL(5'b10101)) dut_b (
    .clk(clk), .clear(clear), .en(en), .mode(mode), .dir(dir), .sin(sin),
    .load_val(load_val), .q(q_b), .step_cnt(cnt_b), .wrap(wrap_b)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
    end
  endtask

  // Reference: q treated as an integer; shifting toward MSB is *2, toward LSB is /2.
  task automatic model_update(input int k);
    int exit_b, entry_b;
    if (clear) begin
      m_q[k] = m_rv[k]; m_cnt[k] = 0; m_wrap[k] = 0;
    end else if (!en) begin
      m_wrap[k] = 0;
    end else if (mode == 2'b11) begin
      m_q[k] = int'(load_val); m_cnt[k] = 0; m_wrap[k] = 0;
    end else begin
      exit_b = dir ? (m_q[k] % 2) : (m_q[k] / (1 << (W-1))) % 2;
      case (mode)
        2'b00:   entry_b = (exit_b == 1 || sin) ? 1 : 0;
        2'b01:   entry_b = 1 - exit_b;
        default: entry_b = sin ? 1 : 0;
      endcase
      if (dir) m_q[k] = m_q[k] / 2 + entry_b * (1 << (W-1));
      else     m_q[k] = ((m_q[k] * 2) + entry_b) & MASK;
      m_cnt[k]  = (m_cnt[k] + 1) % W;
      m_wrap[k] = (m_cnt[k] == 0) ? 1 : 0;
    end
  endtask

  task automatic step(input logic c, input logic e, input logic [1:0] m,
                      input logic d, input logic s, input logic [W-1:0] lv);
    clear = c; en = e; mode = m; dir = d; sin = s; load_val = lv;
    @(posedge clk);
    model_update(0);
    model_update(1);
    #1;
    check("q_a",    int'(q_a),    m_q[0]);
    check("cnt_a",  int'(cnt_a),  m_cnt[0]);
    check("wrap_a", int'(wrap_a), m_wrap[0]);
    check("q_b",    int'(q_b),    m_q[1]);
    check("cnt_b",  int'(cnt_b),  m_cnt[1]);
    check("wrap_b", int'(wrap_b), m_wrap[1]);
    $display("step clr=%0b en=%0b mode=%0d dir=%0b sin=%0b ld=%05b -> q_a=%05b cnt=%0d wrap=%0b q_b=%05b",
             c, e, m, d, s, lv, q_a, cnt_a, wrap_a, q_b);
  endtask

  int ring_q[6]    = '{1, 2, 4, 8, 16, 1};
  int ring_cnt[6]  = '{1, 2, 3, 4, 0, 1};
  int john_q[10]   = '{1, 3, 7, 15, 31, 30, 28, 24, 16, 0};
  int shift_sin[5] = '{1, 0, 1, 1, 0};

  initial begin
    m_q = '{0, 0}; m_cnt = '{0, 0}; m_wrap = '{0, 0};

    // reset with otherwise-active inputs
    step(1, 1, 2'b00, 0, 1, 5'b00000);
    step(1, 1, 2'b00, 0, 1, 5'b00000);
    check("rst_q_a", int'(q_a), 0);
    check("rst_q_b", int'(q_b), 21);
    check("rst_cnt", int'(cnt_a), 0);
    check("rst_wrap", int'(wrap_a), 0);

    // ring, dir=0: single token injected then circulated
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 2'b00, 0, (i == 0), 5'b00000);
      check("ring_q", int'(q_a), ring_q[i]);
      check("ring_cnt", int'(cnt_a), ring_cnt[i]);
      check("ring_wrap", int'(wrap_a), (ring_q[i] == 16) ? 1 : 0);
    end

    // Johnson from all-zero, two full periods
    step(1, 0, 2'b00, 0, 0, 5'b00000);
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 2'b01, 0, $urandom_range(0, 1), 5'b00000);
      check("john_q", int'(q_a), john_q[i % 10]);
    end

    // load then ring toward LSB, then hold
    step(0, 1, 2'b11, 1, 0, 5'b00001);
    check("load_q", int'(q_a), 1);
    check("load_cnt", int'(cnt_a), 0);
    step(0, 1, 2'b00, 1, 0, 5'b00000); check("rr_q", int'(q_a), 16);
    step(0, 1, 2'b00, 1, 0, 5'b00000); check("rr_q", int'(q_a), 8);
    step(0, 1, 2'b00, 1, 0, 5'b00000); check("rr_q", int'(q_a), 4);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 2'b00, 1, 1, 5'b11111);
      check("hold_q", int'(q_a), 4);
      check("hold_cnt", int'(cnt_a), 3);
      check("hold_wrap", int'(wrap_a), 0);
    end

    // serial shift, dir=0
    step(1, 0, 2'b00, 0, 0, 5'b00000);
    for (int i = 0; i < 5; i++) step(0, 1, 2'b10, 0, shift_sin[i][0], 5'b00000);
    check("shift_q", int'(q_a), 22);
    check("shift_cnt", int'(cnt_a), 0);
    check("shift_wrap", int'(wrap_a), 1);

    // clear beats load, then load takes effect
    step(0, 1, 2'b00, 0, 1, 5'b00000);
    step(0, 1, 2'b00, 0, 0, 5'b00000);
    step(1, 1, 2'b11, 0, 0, 5'b11111);
    check("prio_q_a", int'(q_a), 0);
    check("prio_q_b", int'(q_b), 21);
    check("prio_cnt", int'(cnt_a), 0);
    step(0, 1, 2'b11, 0, 0, 5'b11111);
    check("prio_load_q", int'(q_a), 31);
    check("prio_load_cnt", int'(cnt_a), 0);

    // randomized mix of all modes, directions, holds and clears
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0),
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
